// File: rtl/serial_comma_aligner.sv
// serial_comma_aligner
//   Receive-side deserializer for the 10-bit PHY link. Shifts in one serial
//   bit per clock, hunts for the K28.5 comma (either running disparity),
//   aligns the 10-bit symbol boundary to it, acquires lock after
//   LOCK_COMMAS aligned commas and then presents aligned symbols.
//
// Ports
//   CLOCK      in   1   bit clock, one serial bit per rising edge
//   RESET_L    in   1   asynchronous reset, active low
//   IS         in   1   serial data in (first bit of a symbol lands in OP[0])
//   OP         out  10  aligned symbol, held between VALID pulses
//   VALID      out  1   one-cycle strobe: OP carries a new aligned symbol
//   COMMA      out  1   one-cycle strobe alongside VALID when OP is a K28.5
//   LOCK       out  1   high while the FSM is LOCKED
//   ALIGN_ERR  out  1   one-cycle strobe: comma seen off-boundary while LOCKED
//   fsm_state  out  2   current FSM state (0 HUNT, 1 CHECK, 2 LOCKED)
//
// Handshake: VALID is a push-only strobe with no ready/back-pressure; the
// consumer must take OP in the cycle VALID is high. COMMA is only ever high
// together with VALID. A new VALID can occur at most once every 10 cycles.

module serial_comma_aligner #(
    parameter logic [9:0]  COMMA_N     = 10'b0101111100,
    parameter logic [9:0]  COMMA_P     = 10'b1010000011,
    parameter int unsigned LOCK_COMMAS = 3
) (
    input  logic       CLOCK,
    input  logic       RESET_L,
    input  logic       IS,
    output logic [9:0] OP,
    output logic       VALID,
    output logic       COMMA,
    output logic       LOCK,
    output logic       ALIGN_ERR,
    output logic [1:0] fsm_state
);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [2:0] LOCK_N = 3'(LOCK_COMMAS);

    state_t     state_q, state_d;
    logic [9:0] sr_q;
    logic [3:0] phase_q, phase_d;
    logic [2:0] cnt_q, cnt_d, cnt_inc;
    logic [9:0] op_d;
    logic       valid_d, comma_d, err_d;
    logic       cm, bnd;

    // SR holds the last ten bits with the oldest at bit 0, so a complete
    // symbol sits in SR exactly when PHASE reaches 9.
    assign cm      = (sr_q == COMMA_N) || (sr_q == COMMA_P);
    assign bnd     = (phase_q == 4'd9);
    assign cnt_inc = (cnt_q == 3'd7) ? 3'd7 : cnt_q + 3'd1;

    assign LOCK      = (state_q == LOCKED);
    assign fsm_state = state_q;

    always_comb begin
        state_d = state_q;
        phase_d = bnd ? 4'd0 : phase_q + 4'd1;
        cnt_d   = cnt_q;
        op_d    = OP;
        valid_d = 1'b0;
        comma_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            HUNT: begin
                if (cm) begin
                    // The comma just completed; the next bit starts a symbol.
                    phase_d = 4'd0;
                    cnt_d   = 3'd1;
                    state_d = (LOCK_N <= 3'd1) ? LOCKED : CHECK;
                end
            end
            CHECK: begin
                if (bnd && cm) begin
                    cnt_d = cnt_inc;
                    // >= so a re-entry from LOCKED with LOCK_COMMAS=1 still exits.
                    if (cnt_inc >= LOCK_N) begin
                        state_d = LOCKED;
                    end
                end else if (!bnd && cm) begin
                    // Comma at a new offset: restart counting on its alignment.
                    phase_d = 4'd0;
                    cnt_d   = 3'd1;
                end
            end
            LOCKED: begin
                if (bnd) begin
                    op_d    = sr_q;
                    valid_d = 1'b1;
                    comma_d = cm;
                end else if (cm) begin
                    err_d   = 1'b1;
                    phase_d = 4'd0;
                    cnt_d   = 3'd1;
                    state_d = CHECK;
                end
            end
            default: begin
                state_d = HUNT;
            end
        endcase
    end

    always_ff @(posedge CLOCK or negedge RESET_L) begin
        if (!RESET_L) begin
            state_q   <= HUNT;
            sr_q      <= 10'd0;
            phase_q   <= 4'd0;
            cnt_q     <= 3'd0;
            OP        <= 10'd0;
            VALID     <= 1'b0;
            COMMA     <= 1'b0;
            ALIGN_ERR <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= {IS, sr_q[9:1]};
            phase_q   <= phase_d;
            cnt_q     <= cnt_d;
            OP        <= op_d;
            VALID     <= valid_d;
            COMMA     <= comma_d;
            ALIGN_ERR <= err_d;
        end
    end

endmodule
